// File: rtl/l2_cache_tag_requester.sv
// l2_cache_tag_requester
//
// Initiator side of the L2 cache tag bank flex-channel interface. Lookup requests from the L2
// controller are latched and driven to the tag bank on the tag_in/set_in channels. The bank's
// way_out/state_out responses are joined into a single rsp_* beat for the controller. Bank
// flushes are sequenced over flush_in/flush_complete. At most one request or flush is in
// flight at any time.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready/req_tag/req_set
//                                 controller lookup request channel
//   rsp_valid/rsp_ready/rsp_way/rsp_state
//                                 joined response channel to the controller
//   tag_in_valid/tag_in_ready/tag_in, set_in_valid/set_in_ready/set_in
//                                 request channels to the tag bank
//   way_out_valid/way_out_ready/way_out, state_out_valid/state_out_ready/state_out
//                                 response channels from the tag bank
//   flush_req, flush_busy         one-cycle flush command and in-progress flag
//   flush_in_valid/flush_in_ready flush command channel to the bank
//   flush_complete_valid/flush_complete_ready
//                                 flush done channel from the bank
//   err_timeout                   sticky watchdog error
//
// Build option: define L2_TAG_REQ_WATCHDOG_EN to enable the WAIT/FLUSH_WAIT watchdog. Without
// it err_timeout is tied to 0.

module l2_cache_tag_requester #(
   parameter int unsigned TAG_W       = 20,
   parameter int unsigned SET_W       = 8,
   parameter int unsigned WAY_W       = 3,
   parameter int unsigned STATE_W     = 2,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic               clk,
   input  logic               rst,
   // Controller request
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [TAG_W-1:0]   req_tag,
   input  logic [SET_W-1:0]   req_set,
   // Controller response
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [WAY_W-1:0]   rsp_way,
   output logic [STATE_W-1:0] rsp_state,
   // Bank request channels
   output logic               tag_in_valid,
   input  logic               tag_in_ready,
   output logic [TAG_W-1:0]   tag_in,
   output logic               set_in_valid,
   input  logic               set_in_ready,
   output logic [SET_W-1:0]   set_in,
   // Bank response channels
   input  logic               way_out_valid,
   output logic               way_out_ready,
   input  logic [WAY_W-1:0]   way_out,
   input  logic               state_out_valid,
   output logic               state_out_ready,
   input  logic [STATE_W-1:0] state_out,
   // Flush
   input  logic               flush_req,
   output logic               flush_busy,
   output logic               flush_in_valid,
   input  logic               flush_in_ready,
   input  logic               flush_complete_valid,
   output logic               flush_complete_ready,
   // Error
   output logic               err_timeout
);

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWait,
      StResp,
      StFlushIssue,
      StFlushWait
   } state_e;

   state_e state_q;

   // Registered "in IDLE" flag; req_ready also has to drop combinationally when flush_req
   // arrives because flush wins over a simultaneous request.
   logic idle_q;
   logic tag_done_q, set_done_q;
   logic way_captured_q, state_captured_q;

   logic tag_hs, set_hs, way_hs, st_hs;
   logic tag_fin, set_fin, way_fin, st_fin;

   assign req_ready = idle_q && !flush_req;

   assign tag_hs  = tag_in_valid && tag_in_ready;
   assign set_hs  = set_in_valid && set_in_ready;
   assign way_hs  = way_out_valid && way_out_ready;
   assign st_hs   = state_out_valid && state_out_ready;

   // A channel counts as finished if it completed earlier or is completing this cycle.
   assign tag_fin = tag_done_q || tag_hs;
   assign set_fin = set_done_q || set_hs;
   assign way_fin = way_captured_q || way_hs;
   assign st_fin  = state_captured_q || st_hs;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q              <= StIdle;
         idle_q               <= 1'b0;
         tag_done_q           <= 1'b0;
         set_done_q           <= 1'b0;
         way_captured_q       <= 1'b0;
         state_captured_q     <= 1'b0;
         rsp_valid            <= 1'b0;
         rsp_way              <= '0;
         rsp_state            <= '0;
         tag_in_valid         <= 1'b0;
         tag_in               <= '0;
         set_in_valid         <= 1'b0;
         set_in               <= '0;
         way_out_ready        <= 1'b0;
         state_out_ready      <= 1'b0;
         flush_busy           <= 1'b0;
         flush_in_valid       <= 1'b0;
         flush_complete_ready <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               idle_q <= 1'b1;
               if (flush_req) begin
                  idle_q         <= 1'b0;
                  flush_busy     <= 1'b1;
                  flush_in_valid <= 1'b1;
                  state_q        <= StFlushIssue;
               end else if (req_valid && req_ready) begin
                  idle_q       <= 1'b0;
                  tag_in       <= req_tag;
                  set_in       <= req_set;
                  tag_in_valid <= 1'b1;
                  set_in_valid <= 1'b1;
                  state_q      <= StIssue;
               end
            end

            StIssue: begin
               if (tag_hs) begin
                  tag_in_valid <= 1'b0;
                  tag_done_q   <= 1'b1;
               end
               if (set_hs) begin
                  set_in_valid <= 1'b0;
                  set_done_q   <= 1'b1;
               end
               if (tag_fin && set_fin) begin
                  tag_done_q      <= 1'b0;
                  set_done_q      <= 1'b0;
                  way_out_ready   <= 1'b1;
                  state_out_ready <= 1'b1;
                  state_q         <= StWait;
               end
            end

            StWait: begin
               if (way_hs) begin
                  rsp_way        <= way_out;
                  way_captured_q <= 1'b1;
                  way_out_ready  <= 1'b0;
               end
               if (st_hs) begin
                  rsp_state        <= state_out;
                  state_captured_q <= 1'b1;
                  state_out_ready  <= 1'b0;
               end
               if (way_fin && st_fin) begin
                  rsp_valid <= 1'b1;
                  state_q   <= StResp;
               end
            end

            StResp: begin
               if (rsp_ready) begin
                  rsp_valid        <= 1'b0;
                  way_captured_q   <= 1'b0;
                  state_captured_q <= 1'b0;
                  idle_q           <= 1'b1;
                  state_q          <= StIdle;
               end
            end

            StFlushIssue: begin
               if (flush_in_ready) begin
                  flush_in_valid       <= 1'b0;
                  flush_complete_ready <= 1'b1;
                  state_q              <= StFlushWait;
               end
            end

            StFlushWait: begin
               if (flush_complete_valid) begin
                  flush_complete_ready <= 1'b0;
                  flush_busy           <= 1'b0;
                  idle_q               <= 1'b1;
                  state_q              <= StIdle;
               end
            end

            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

`ifdef L2_TAG_REQ_WATCHDOG_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

   logic [CntW-1:0] wd_cnt_q;
   logic [CntW-1:0] wd_cnt_inc;
   logic            waiting;

   assign waiting    = (state_q == StWait) || (state_q == StFlushWait);
   assign wd_cnt_inc = wd_cnt_q + CntW'(1);

   // The counter sits at 0 outside the waiting states, so it starts from 0 on every entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt_q    <= '0;
         err_timeout <= 1'b0;
      end else if (waiting) begin
         if (wd_cnt_q != CntW'(TIMEOUT_CYC)) begin
            wd_cnt_q <= wd_cnt_inc;
         end
         if (wd_cnt_inc == CntW'(TIMEOUT_CYC)) begin
            err_timeout <= 1'b1;
         end
      end else begin
         wd_cnt_q <= '0;
      end
   end
`else
   logic unused_timeout_cyc;
   assign unused_timeout_cyc = ^TIMEOUT_CYC;
   assign err_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_l2_cache_tag_requester.sv
module tb_l2_cache_tag_requester;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [19:0] req_tag;
   logic [7:0]  req_set;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [2:0]  rsp_way;
   logic [1:0]  rsp_state;
   logic        tag_in_valid;
   logic        tag_in_ready;
   logic [19:0] tag_in;
   logic        set_in_valid;
   logic        set_in_ready;
   logic [7:0]  set_in;
   logic        way_out_valid;
   logic        way_out_ready;
   logic [2:0]  way_out;
   logic        state_out_valid;
   logic        state_out_ready;
   logic [1:0]  state_out;
   logic        flush_req;
   logic        flush_busy;
   logic        flush_in_valid;
   logic        flush_in_ready;
   logic        flush_complete_valid;
   logic        flush_complete_ready;
   logic        err_timeout;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   l2_cache_tag_requester #(
      .TAG_W       (20),
      .SET_W       (8),
      .WAY_W       (3),
      .STATE_W     (2),
      .TIMEOUT_CYC (8)
   ) dut (
      .clk                  (clk),
      .rst                  (rst),
      .req_valid            (req_valid),
      .req_ready            (req_ready),
      .req_tag              (req_tag),
      .req_set              (req_set),
      .rsp_valid            (rsp_valid),
      .rsp_ready            (rsp_ready),
      .rsp_way              (rsp_way),
      .rsp_state            (rsp_state),
      .tag_in_valid         (tag_in_valid),
      .tag_in_ready         (tag_in_ready),
      .tag_in               (tag_in),
      .set_in_valid         (set_in_valid),
      .set_in_ready         (set_in_ready),
      .set_in               (set_in),
      .way_out_valid        (way_out_valid),
      .way_out_ready        (way_out_ready),
      .way_out              (way_out),
      .state_out_valid      (state_out_valid),
      .state_out_ready      (state_out_ready),
      .state_out            (state_out),
      .flush_req            (flush_req),
      .flush_busy           (flush_busy),
      .flush_in_valid       (flush_in_valid),
      .flush_in_ready       (flush_in_ready),
      .flush_complete_valid (flush_complete_valid),
      .flush_complete_ready (flush_complete_ready),
      .err_timeout          (err_timeout)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet_inputs();
      req_valid            = 1'b0;
      req_tag              = '0;
      req_set              = '0;
      rsp_ready            = 1'b0;
      tag_in_ready         = 1'b0;
      set_in_ready         = 1'b0;
      way_out_valid        = 1'b0;
      way_out              = '0;
      state_out_valid      = 1'b0;
      state_out            = '0;
      flush_req            = 1'b0;
      flush_in_ready       = 1'b0;
      flush_complete_valid = 1'b0;
   endtask

   task automatic test_reset();
      logic [41:0] outs;
      quiet_inputs();
      rst       = 1'b1;
      req_valid = 1'b1;
      tick();
      tick();
      outs = {req_ready, rsp_valid, rsp_way, rsp_state, tag_in_valid, tag_in, set_in_valid,
              set_in, way_out_ready, state_out_ready, flush_busy, flush_in_valid,
              flush_complete_ready, err_timeout};
      n_vec++;
      if (outs !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: got %h want 0", outs);
      end
      rst       = 1'b0;
      req_valid = 1'b0;
      tick();
      n_vec++;
      if (req_ready !== 1'b1) begin
         n_err++;
         $display("FAIL reset_req_ready: got %b want 1", req_ready);
      end
   endtask

   task automatic test_basic();
      quiet_inputs();
      tag_in_ready = 1'b1;
      set_in_ready = 1'b1;
      req_valid    = 1'b1;
      req_tag      = 20'h12345;
      req_set      = 8'h3C;
      tick();  // cycle 0 handshake
      req_valid       = 1'b0;
      way_out_valid   = 1'b1;
      way_out         = 3'd5;
      state_out_valid = 1'b1;
      state_out       = 2'd2;
      n_vec++;
      if ({tag_in_valid, set_in_valid, tag_in, set_in} !== {2'b11, 20'h12345, 8'h3C}) begin
         n_err++;
         $display("FAIL basic_issue: got %b%b %h %h want 11 12345 3c",
                  tag_in_valid, set_in_valid, tag_in, set_in);
      end
      tick();
      n_vec++;
      if ({tag_in_valid, set_in_valid, way_out_ready, state_out_ready, rsp_valid} !== 5'b00110)
      begin
         n_err++;
         $display("FAIL basic_wait: got %b%b%b%b%b want 00110", tag_in_valid, set_in_valid,
                  way_out_ready, state_out_ready, rsp_valid);
      end
      tick();
      way_out_valid   = 1'b0;
      state_out_valid = 1'b0;
      n_vec++;
      if ({rsp_valid, rsp_way, rsp_state, way_out_ready} !== {1'b1, 3'd5, 2'd2, 1'b0}) begin
         n_err++;
         $display("FAIL basic_rsp: got v=%b way=%0d st=%0d wr=%b want v=1 way=5 st=2 wr=0",
                  rsp_valid, rsp_way, rsp_state, way_out_ready);
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      n_vec++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL basic_done: got v=%b rr=%b want v=0 rr=1", rsp_valid, req_ready);
      end
   endtask

   task automatic test_split();
      quiet_inputs();
      tag_in_ready = 1'b1;
      req_valid    = 1'b1;
      req_tag      = 20'hABCDE;
      req_set      = 8'h07;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++;
         if ({tag_in_valid, set_in_valid, set_in, way_out_ready} !== {2'b01, 8'h07, 1'b0}) begin
            n_err++;
            $display("FAIL split_set_hold[%0d]: got tv=%b sv=%b set=%h wr=%b want 0 1 07 0",
                     i, tag_in_valid, set_in_valid, set_in, way_out_ready);
         end
      end
      set_in_ready = 1'b1;
      tick();
      set_in_ready    = 1'b0;
      state_out_valid = 1'b1;
      state_out       = 2'd1;
      n_vec++;
      if ({set_in_valid, way_out_ready, state_out_ready} !== 3'b011) begin
         n_err++;
         $display("FAIL split_enter_wait: got %b%b%b want 011", set_in_valid, way_out_ready,
                  state_out_ready);
      end
      tick();
      state_out_valid = 1'b0;
      n_vec++;
      if ({state_out_ready, way_out_ready, rsp_valid} !== 3'b010) begin
         n_err++;
         $display("FAIL split_state_first: got %b%b%b want 010", state_out_ready,
                  way_out_ready, rsp_valid);
      end
      tick();
      way_out_valid = 1'b1;
      way_out       = 3'd3;
      n_vec++;
      if (rsp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL split_no_early_rsp: got %b want 0", rsp_valid);
      end
      tick();
      way_out_valid = 1'b0;
      way_out       = 3'd0;
      for (int i = 0; i < 4; i++) begin
         n_vec++;
         if ({rsp_valid, rsp_way, rsp_state} !== {1'b1, 3'd3, 2'd1}) begin
            n_err++;
            $display("FAIL split_rsp_hold[%0d]: got v=%b way=%0d st=%0d want 1 3 1",
                     i, rsp_valid, rsp_way, rsp_state);
         end
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      n_vec++;
      if ({rsp_valid, req_ready} !== 2'b01) begin
         n_err++;
         $display("FAIL split_done: got v=%b rr=%b want 0 1", rsp_valid, req_ready);
      end
   endtask

   task automatic test_flush_priority();
      quiet_inputs();
      flush_req = 1'b1;
      req_valid = 1'b1;
      req_tag   = 20'h00F0F;
      req_set   = 8'h55;
      #1;
      n_vec++;
      if (req_ready !== 1'b0) begin
         n_err++;
         $display("FAIL flush_req_ready_low: got %b want 0", req_ready);
      end
      tick();
      flush_req      = 1'b0;
      flush_in_ready = 1'b1;
      n_vec++;
      if ({flush_in_valid, flush_busy, tag_in_valid, req_ready} !== 4'b1100) begin
         n_err++;
         $display("FAIL flush_issue: got %b%b%b%b want 1100", flush_in_valid, flush_busy,
                  tag_in_valid, req_ready);
      end
      tick();
      flush_in_ready = 1'b0;
      n_vec++;
      if ({flush_in_valid, flush_complete_ready, flush_busy} !== 3'b011) begin
         n_err++;
         $display("FAIL flush_wait: got %b%b%b want 011", flush_in_valid,
                  flush_complete_ready, flush_busy);
      end
      repeat (9) tick();
      flush_complete_valid = 1'b1;
      n_vec++;
      if ({flush_busy, req_ready} !== 2'b10) begin
         n_err++;
         $display("FAIL flush_still_busy: got %b%b want 10", flush_busy, req_ready);
      end
      tick();
      flush_complete_valid = 1'b0;
      n_vec++;
      if ({flush_busy, flush_complete_ready, req_ready} !== 3'b001) begin
         n_err++;
         $display("FAIL flush_done: got %b%b%b want 001", flush_busy, flush_complete_ready,
                  req_ready);
      end
      tick();
      req_valid = 1'b0;
      n_vec++;
      if ({tag_in_valid, tag_in, set_in} !== {1'b1, 20'h00F0F, 8'h55}) begin
         n_err++;
         $display("FAIL flush_then_req: got v=%b tag=%h set=%h want 1 00f0f 55",
                  tag_in_valid, tag_in, set_in);
      end
      // Drain the lookup with an always-ready bank.
      tag_in_ready    = 1'b1;
      set_in_ready    = 1'b1;
      way_out_valid   = 1'b1;
      way_out         = 3'd7;
      state_out_valid = 1'b1;
      state_out       = 2'd3;
      tick();
      tick();
      rsp_ready = 1'b1;
      n_vec++;
      if ({rsp_valid, rsp_way, rsp_state} !== {1'b1, 3'd7, 2'd3}) begin
         n_err++;
         $display("FAIL flush_then_rsp: got v=%b way=%0d st=%0d want 1 7 3",
                  rsp_valid, rsp_way, rsp_state);
      end
      tick();
      quiet_inputs();
   endtask

   task automatic test_reset_mid_wait();
      quiet_inputs();
      tag_in_ready = 1'b1;
      set_in_ready = 1'b1;
      req_valid    = 1'b1;
      req_tag      = 20'h0BEEF;
      req_set      = 8'h11;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      n_vec++;
      if ({way_out_ready, rsp_valid} !== 2'b10) begin
         n_err++;
         $display("FAIL rstwait_waiting: got %b%b want 10", way_out_ready, rsp_valid);
      end
      rst           = 1'b1;
      way_out_valid = 1'b1;
      way_out       = 3'd6;
      tick();
      rst = 1'b0;
      tick();
      n_vec++;
      if ({rsp_valid, way_out_ready, req_ready} !== 3'b001) begin
         n_err++;
         $display("FAIL rstwait_idle: got v=%b wr=%b rr=%b want 0 0 1", rsp_valid,
                  way_out_ready, req_ready);
      end
      // New lookup; way_out_valid has been held high throughout.
      state_out_valid = 1'b1;
      state_out       = 2'd3;
      req_valid       = 1'b1;
      req_tag         = 20'h0ABCD;
      req_set         = 8'h81;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      way_out_valid   = 1'b0;
      state_out_valid = 1'b0;
      n_vec++;
      if ({rsp_valid, rsp_way, rsp_state} !== {1'b1, 3'd6, 2'd3}) begin
         n_err++;
         $display("FAIL rstwait_new_rsp: got v=%b way=%0d st=%0d want 1 6 3",
                  rsp_valid, rsp_way, rsp_state);
      end
      rsp_ready = 1'b1;
      tick();
      quiet_inputs();
   endtask

   task automatic test_watchdog();
      logic exp_err;
`ifdef L2_TAG_REQ_WATCHDOG_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      quiet_inputs();
      tag_in_ready = 1'b1;
      set_in_ready = 1'b1;
      req_valid    = 1'b1;
      req_tag      = 20'h77777;
      req_set      = 8'hEE;
      tick();
      req_valid = 1'b0;
      tick();  // now in WAIT
      repeat (7) tick();
      n_vec++;
      if (err_timeout !== 1'b0) begin
         n_err++;
         $display("FAIL wd_before_limit: got %b want 0", err_timeout);
      end
      tick();
      n_vec++;
      if (err_timeout !== exp_err) begin
         n_err++;
         $display("FAIL wd_at_limit: got %b want %b", err_timeout, exp_err);
      end
      way_out_valid   = 1'b1;
      way_out         = 3'd1;
      state_out_valid = 1'b1;
      state_out       = 2'd0;
      tick();
      way_out_valid   = 1'b0;
      state_out_valid = 1'b0;
      rsp_ready       = 1'b1;
      n_vec++;
      if ({rsp_valid, rsp_way, rsp_state} !== {1'b1, 3'd1, 2'd0}) begin
         n_err++;
         $display("FAIL wd_late_rsp: got v=%b way=%0d st=%0d want 1 1 0",
                  rsp_valid, rsp_way, rsp_state);
      end
      tick();
      rsp_ready = 1'b0;
      tick();
      n_vec++;
      if ({err_timeout, rsp_valid, req_ready} !== {exp_err, 2'b01}) begin
         n_err++;
         $display("FAIL wd_sticky: got err=%b v=%b rr=%b want err=%b v=0 rr=1",
                  err_timeout, rsp_valid, req_ready, exp_err);
      end
   endtask

   initial begin
      quiet_inputs();
      rst = 1'b1;
      test_reset();
      test_basic();
      test_split();
      test_flush_priority();
      test_reset_mid_wait();
      test_watchdog();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
